sincos_arbiter: RTL and testbench

- Shares one fixed-latency sincos engine (double-precision theta in, sin/cos out) between NUM_REQ requesters, such as several chaotic-oscillator channels.
- Grants requests round-robin, one per cycle, and issues the theta to the engine.
- The engine carries no tag, so the arbiter records the requester ID in an in-order tag FIFO. It pops one tag per engine result and routes that result back to its requester.
- Credit-limits outstanding operations and flags protocol errors.

---
 rtl/sincos_arb_pkg.sv | 17 +
 rtl/sincos_arb_tag_fifo.sv | 60 ++++++
 rtl/sincos_arbiter.sv | 146 ++++++++++++++
 tb/tb_sincos_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_arb_pkg.sv
// Shared constants and helpers for the sincos engine arbiter.
package sincos_arb_pkg;

    localparam int ERR_UNDERFLOW      = 0;
    localparam int ERR_VALID_MISMATCH = 1;
    localparam int ERR_RESERVED       = 2;

    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // The round-robin pointer starts on the last requester so requester 0 wins first.
    function automatic int reset_ptr(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/sincos_arb_tag_fifo.sv
// In-order FIFO of requester tags for operations issued to the untagged engine.
module sincos_arb_tag_fifo
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 2
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sincos_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sincos engine between NUM_REQ requesters.
// Optional per-requester issue and credit-stall counters are built when SINCOS_ARB_PERF_EN is defined.
module sincos_arbiter
    import sincos_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 256
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_theta,
    output logic                            eng_theta_valid,
    output logic [DATA_WIDTH-1:0]           eng_theta,
    input  logic                            eng_sin_valid,
    input  logic [DATA_WIDTH-1:0]           eng_sin,
    input  logic                            eng_cos_valid,
    input  logic [DATA_WIDTH-1:0]           eng_cos,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_sin,
    output logic [DATA_WIDTH-1:0]           rsp_cos,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic [2:0]                      err_flags
`ifdef SINCOS_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]           perf_issue_cnt,
    output logic [31:0]                     perf_stall_cnt
`endif
);

    localparam int TAG_W = tag_width(NUM_REQ);
    localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(reset_ptr(NUM_REQ));

    logic [TAG_W-1:0]      ptr;
    logic [TAG_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] sel_theta;
    logic                  credit_ok;
    logic                  result_pair;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [TAG_W-1:0]      head_tag;
    logic [NUM_REQ-1:0]    head_onehot;
    int                    idx;

    // A full tag FIFO is exactly the credit limit being reached.
    assign credit_ok   = ~fifo_full;
    assign result_pair = eng_sin_valid & eng_cos_valid;
    assign pop         = result_pair & ~fifo_empty;

    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        req_ready   = '0;
        head_onehot = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (credit_ok && !grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(idx);
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_theta = req_theta[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        head_onehot[head_tag] = 1'b1;
    end

    sincos_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_any),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_theta_valid <= 1'b0;
            eng_theta       <= '0;
            ptr             <= PTR_RST;
        end else begin
            eng_theta_valid <= grant_any;
            if (grant_any) begin
                eng_theta <= sel_theta;
                ptr       <= grant_idx;
            end
        end
    end

    // Results return in issue order, so the FIFO head names the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_sin   <= '0;
            rsp_cos   <= '0;
            err_flags <= '0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid <= head_onehot;
                rsp_sin   <= eng_sin;
                rsp_cos   <= eng_cos;
            end
            if (result_pair && fifo_empty) begin
                err_flags[ERR_UNDERFLOW] <= 1'b1;
            end
            if (eng_sin_valid ^ eng_cos_valid) begin
                err_flags[ERR_VALID_MISMATCH] <= 1'b1;
            end
            err_flags[ERR_RESERVED] <= 1'b0;
        end
    end

`ifdef SINCOS_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    perf_issue_cnt[i*32 +: 32] <= perf_issue_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if ((|req_valid) && !credit_ok) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sincos_arbiter.sv
// Directed self-checking bench: a 149-cycle engine model on the main instance, a hand-driven engine on a credit-8 instance.
module tb_sincos_arbiter;

    localparam int LAT = 149;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_theta;
    logic         eng_theta_valid;
    logic [63:0]  eng_theta;
    logic         eng_sin_valid;
    logic         eng_cos_valid;
    logic [63:0]  eng_sin;
    logic [63:0]  eng_cos;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_sin;
    logic [63:0]  rsp_cos;
    logic [8:0]   outstanding;
    logic [2:0]   err_flags;

    logic [3:0]   cr_req_valid;
    logic [3:0]   cr_req_ready;
    logic [255:0] cr_req_theta;
    logic         cr_eng_theta_valid;
    logic [63:0]  cr_eng_theta;
    logic         cr_sin_valid;
    logic         cr_cos_valid;
    logic [63:0]  cr_sin;
    logic [63:0]  cr_cos;
    logic [3:0]   cr_rsp_valid;
    logic [63:0]  cr_rsp_sin;
    logic [63:0]  cr_rsp_cos;
    logic [3:0]   cr_outstanding;
    logic [2:0]   cr_err_flags;

`ifdef SINCOS_ARB_PERF_EN
    logic [127:0] perf_issue_cnt;
    logic [31:0]  perf_stall_cnt;
    logic [127:0] cr_perf_issue_cnt;
    logic [31:0]  cr_perf_stall_cnt;
`endif

    sincos_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_OUTSTANDING(256)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_theta       (req_theta),
        .eng_theta_valid (eng_theta_valid),
        .eng_theta       (eng_theta),
        .eng_sin_valid   (eng_sin_valid),
        .eng_sin         (eng_sin),
        .eng_cos_valid   (eng_cos_valid),
        .eng_cos         (eng_cos),
        .rsp_valid       (rsp_valid),
        .rsp_sin         (rsp_sin),
        .rsp_cos         (rsp_cos),
        .outstanding     (outstanding),
        .err_flags       (err_flags)
`ifdef SINCOS_ARB_PERF_EN
        ,
        .perf_issue_cnt  (perf_issue_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    sincos_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_OUTSTANDING(8)) dut_cr (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (cr_req_valid),
        .req_ready       (cr_req_ready),
        .req_theta       (cr_req_theta),
        .eng_theta_valid (cr_eng_theta_valid),
        .eng_theta       (cr_eng_theta),
        .eng_sin_valid   (cr_sin_valid),
        .eng_sin         (cr_sin),
        .eng_cos_valid   (cr_cos_valid),
        .eng_cos         (cr_cos),
        .rsp_valid       (cr_rsp_valid),
        .rsp_sin         (cr_rsp_sin),
        .rsp_cos         (cr_rsp_cos),
        .outstanding     (cr_outstanding),
        .err_flags       (cr_err_flags)
`ifdef SINCOS_ARB_PERF_EN
        ,
        .perf_issue_cnt  (cr_perf_issue_cnt),
        .perf_stall_cnt  (cr_perf_stall_cnt)
`endif
    );

    // Engine model: sin = theta + 1, cos = theta + 2, LAT cycles after the issue strobe.
    logic        pipe_v [LAT];
    logic [63:0] pipe_d [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= eng_theta_valid;
            pipe_d[0] <= eng_theta;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign eng_sin_valid = pipe_v[LAT-1];
    assign eng_cos_valid = pipe_v[LAT-1];
    assign eng_sin       = pipe_d[LAT-1] + 64'd1;
    assign eng_cos       = pipe_d[LAT-1] + 64'd2;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid);
        req_valid = valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps negedge by negedge until the main instance reports a result; bounded.
    task automatic waitRsp(output int at);
        int n;
        n = 0;
        while (rsp_valid === 4'b0000 && n < 400) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
    endtask

    logic [63:0] th [4];
    int t0;
    int at;

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_theta    = '0;
        cr_req_valid = '0;
        cr_req_theta = '0;
        cr_sin_valid = 1'b0;
        cr_cos_valid = 1'b0;
        cr_sin       = '0;
        cr_cos       = '0;
        for (int i = 0; i < 4; i++) begin
            th[i] = 64'h4000_0000_0000_0000 | 64'(i * 16 + 3);
            req_theta[i*64 +: 64] = th[i];
        end
        #12;
        checkOutput("reset_theta_valid", {63'd0, eng_theta_valid}, 64'd0);
        checkOutput("reset_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        checkOutput("reset_outstanding", {55'd0, outstanding}, 64'd0);
        checkOutput("reset_err", {61'd0, err_flags}, 64'd0);
        checkOutput("reset_ready", {60'd0, req_ready}, 64'd0);
        checkOutput("reset_cr_outstanding", {60'd0, cr_outstanding}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Round robin: all four hold valid for eight cycles.
        tick();
        applyStimulus(4'b1111);
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rr_ready", {60'd0, req_ready}, 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                checkOutput("rr_eng_theta", eng_theta, th[(k-1) % 4]);
            end
            tick();
        end
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("rr_last_theta", eng_theta, th[3]);
        checkOutput("rr_outstanding", {55'd0, outstanding}, 64'd8);
        waitRsp(at);
        checkOutput("rr_latency", 64'(at - t0), 64'd151);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_rsp_valid", {60'd0, rsp_valid}, 64'(4'b0001 << (k % 4)));
            checkOutput("rr_rsp_sin", rsp_sin, th[k % 4] + 64'd1);
            checkOutput("rr_rsp_cos", rsp_cos, th[k % 4] + 64'd2);
            @(negedge clk);
        end
        checkOutput("rr_drained", {55'd0, outstanding}, 64'd0);
        checkOutput("rr_rsp_idle", {60'd0, rsp_valid}, 64'd0);

        // Single requester 2 with theta = 1.0.
        tick();
        req_theta[2*64 +: 64] = 64'h3FF0_0000_0000_0000;
        applyStimulus(4'b0100);
        t0 = cyc;
        @(negedge clk);
        checkOutput("single_ready", {60'd0, req_ready}, 64'h4);
        tick();
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("single_issue_valid", {63'd0, eng_theta_valid}, 64'd1);
        checkOutput("single_issue_theta", eng_theta, 64'h3FF0_0000_0000_0000);
        checkOutput("single_outstanding", {55'd0, outstanding}, 64'd1);
        waitRsp(at);
        checkOutput("single_latency", 64'(at - t0), 64'd151);
        checkOutput("single_rsp_valid", {60'd0, rsp_valid}, 64'h4);
        checkOutput("single_rsp_sin", rsp_sin, 64'h3FF0_0000_0000_0001);
        checkOutput("single_rsp_cos", rsp_cos, 64'h3FF0_0000_0000_0002);
        @(negedge clk);
        checkOutput("single_rsp_pulse", {60'd0, rsp_valid}, 64'd0);
        checkOutput("single_drained", {55'd0, outstanding}, 64'd0);

        // Reset with 50 operations in flight.
        tick();
        req_theta[0*64 +: 64] = 64'h4010_0000_0000_0000;
        applyStimulus(4'b0001);
        repeat (50) tick();
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("inflight_outstanding", {55'd0, outstanding}, 64'd50);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_outstanding", {55'd0, outstanding}, 64'd0);
        checkOutput("midreset_theta_valid", {63'd0, eng_theta_valid}, 64'd0);
        checkOutput("midreset_theta", eng_theta, 64'd0);
        checkOutput("midreset_rsp_sin", rsp_sin, 64'd0);
        checkOutput("midreset_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        req_theta[1*64 +: 64] = 64'h4020_0000_0000_0000;
        applyStimulus(4'b0010);
        t0 = cyc;
        @(negedge clk);
        checkOutput("postreset_ready", {60'd0, req_ready}, 64'h2);
        tick();
        applyStimulus(4'b0000);
        @(negedge clk);
        waitRsp(at);
        checkOutput("postreset_latency", 64'(at - t0), 64'd151);
        checkOutput("postreset_rsp_valid", {60'd0, rsp_valid}, 64'h2);
        checkOutput("postreset_rsp_sin", rsp_sin, 64'h4020_0000_0000_0001);
        checkOutput("main_err_clean", {61'd0, err_flags}, 64'd0);

        // Protocol errors on the hand-driven instance.
        tick();
        cr_sin_valid = 1'b1;
        cr_cos_valid = 1'b1;
        cr_sin       = 64'hAAAA;
        cr_cos       = 64'hBBBB;
        tick();
        cr_sin_valid = 1'b0;
        cr_cos_valid = 1'b0;
        @(negedge clk);
        checkOutput("underflow_err", {61'd0, cr_err_flags}, 64'b001);
        checkOutput("underflow_no_rsp", {60'd0, cr_rsp_valid}, 64'd0);
        tick();
        cr_sin_valid = 1'b1;
        tick();
        cr_sin_valid = 1'b0;
        @(negedge clk);
        checkOutput("mismatch_err", {61'd0, cr_err_flags}, 64'b011);
        checkOutput("mismatch_no_rsp", {60'd0, cr_rsp_valid}, 64'd0);
        checkOutput("mismatch_outstanding", {60'd0, cr_outstanding}, 64'd0);

        // Credit limit of 8 with requester 0 streaming; a pop in cycle 12 frees a credit for cycle 13.
        tick();
        cr_req_theta[0*64 +: 64] = 64'h4030_0000_0000_0000;
        cr_req_valid = 4'b0001;
        for (int k = 0; k < 13; k++) begin
            if (k == 12) begin
                cr_sin_valid = 1'b1;
                cr_cos_valid = 1'b1;
                cr_sin       = 64'h1111;
                cr_cos       = 64'h2222;
            end
            @(negedge clk);
            checkOutput("credit_ready", {60'd0, cr_req_ready}, (k < 8) ? 64'h1 : 64'h0);
            if (k == 8) begin
                checkOutput("credit_full", {60'd0, cr_outstanding}, 64'd8);
            end
            tick();
            if (k == 12) begin
                cr_sin_valid = 1'b0;
                cr_cos_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("credit_released_ready", {60'd0, cr_req_ready}, 64'h1);
        checkOutput("credit_after_pop", {60'd0, cr_outstanding}, 64'd7);
        checkOutput("credit_rsp_valid", {60'd0, cr_rsp_valid}, 64'h1);
        checkOutput("credit_rsp_sin", cr_rsp_sin, 64'h1111);
        tick();
        cr_req_valid = 4'b0000;
        @(negedge clk);
        checkOutput("credit_refilled", {60'd0, cr_outstanding}, 64'd8);

        // Drain the eight outstanding operations.
        tick();
        cr_sin_valid = 1'b1;
        cr_cos_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checkOutput("drain_rsp_valid", {60'd0, cr_rsp_valid}, 64'h1);
            end
            tick();
        end
        cr_sin_valid = 1'b0;
        cr_cos_valid = 1'b0;
        @(negedge clk);
        checkOutput("drain_last_rsp", {60'd0, cr_rsp_valid}, 64'h1);
        checkOutput("drain_outstanding", {60'd0, cr_outstanding}, 64'd0);
        checkOutput("drain_err_kept", {61'd0, cr_err_flags}, 64'b011);

`ifdef SINCOS_ARB_PERF_EN
        checkOutput("perf_cr_issue0", {32'd0, cr_perf_issue_cnt[31:0]}, 64'd9);
        checkOutput("perf_cr_issue1", {32'd0, cr_perf_issue_cnt[63:32]}, 64'd0);
        checkOutput("perf_cr_stall", {32'd0, cr_perf_stall_cnt}, 64'd5);
        checkOutput("perf_main_issue0", {32'd0, perf_issue_cnt[31:0]}, 64'd0);
        checkOutput("perf_main_issue1", {32'd0, perf_issue_cnt[63:32]}, 64'd1);
        checkOutput("perf_main_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
